ex_mem_stage: RTL
=================

# ex_mem_stage

Execute-to-memory pipeline register of the hybrid ARM/MIPS datapath, directly downstream of the ALU. It captures the ALU result and the Z/N/V flags, and holds the architectural NZV flag register. It evaluates the 4-bit ARM condition field of the instruction currently in execute against those flags and turns failing instructions into bubbles. It also supports stall and flush from hazard control and counts annulled instructions.

## Interface
- N, 32, datapath width (same as ALU)
- RW, 4, destination register address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold every register this cycle
- flush  in  1  insert bubble; overrides stall
- in_valid  in  1  execute stage holds a real instruction
- alu_result  in  N  ALU result
- alu_z, alu_n, alu_v  in  1 each  ALU flags for alu_result
- set_flags  in  1  instruction updates NZV (ARM S-bit; 0 for MIPS ops)
- cond  in  4  ARM condition field (MIPS ops drive 4'b1110)
- reg_we_in, mem_we_in  in  1 each  register-file / memory write enables
- rd_in  in  RW  destination register
- store_data_in  in  N  data for stores
- cond_pass  out  1  combinational: cond true under current NZV
- out_valid, out_reg_we, out_mem_we  out  1 each  registered stage outputs
- out_result, out_store_data  out  N  registered
- out_rd  out  RW  registered
- flags_nzv  out  3  architectural flags {N,Z,V}
- annul_count  out  16  wrapping count of instructions annulled by cond

## Operation
- Condition decode on flags_nzv (no C flag exists in this datapath):
  - EQ 0000: Z. NE 0001: !Z. MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - GE 1010: N==V. LT 1011: N!=V. GT 1100: !Z & N==V. LE 1101: Z | N!=V. AL 1110: 1.
  - 0010, 0011, 1000, 1001, 1111: 0 (carry-based or reserved; never execute).
- capture = in_valid & !stall & !flush.
- exec = capture & cond_pass.
- On each rising edge, priority order:
  - flush: out_valid, out_reg_we, out_mem_we <= 0. Data outputs hold their values. Flags and counter unchanged.
  - else if stall: all registers hold.
  - else:
    - out_valid <= exec.
    - out_reg_we <= exec & reg_we_in.
    - out_mem_we <= exec & mem_we_in.
    - out_result, out_store_data, out_rd <= inputs, loaded unconditionally.
- Flag update: if exec & set_flags, then flags_nzv <= {alu_n, alu_z, alu_v}. Annulled, stalled and flushed instructions never write flags.
- Annul counter: if capture & !cond_pass, annul_count increments. It wraps 16'hFFFF -> 0.
- in_valid=0 with no stall/flush:
  - Produces a bubble: out_valid=0, enables 0.
  - Flags and counter unchanged.
- No internal state machine beyond the stage register.
  - The stage is one slot: FULL when out_valid=1, else EMPTY.
  - Transitions follow exec, stall and flush as above.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - out_valid, out_reg_we, out_mem_we = 0.
  - out_result = 0, out_store_data = 0, out_rd = 0.
  - flags_nzv = 3'b000, annul_count = 0.
- Reset asserted mid-operation: all outputs go to the reset values immediately, without waiting for clk. The in-flight instruction is lost.
- Latency: one cycle from inputs to out_* outputs.
- cond_pass is combinational from cond and flags_nzv. It has no path from the same-cycle alu_* inputs.
- Back-to-back flag dependency: a flag-setting instruction captured at edge k is visible to the cond of the instruction in execute during cycle k+1. No bypass is required.
- Stall held for M cycles: outputs, flags and counter are frozen for M cycles. The held instruction is captured on the first edge with stall=0.
- flush and stall together: flush wins and a bubble is inserted.

## Test plan
- Reset: drive random inputs with reset=1 -> all outputs 0. Assert reset between edges -> outputs clear before the next edge.
- Flags plus EQ:
  - SUBS result 0 (alu_z=1, set_flags=1, cond=1110) -> flags_nzv=3'b010 next cycle.
  - Following cond=0000, reg_we_in=1 -> out_valid=1, out_reg_we=1.
  - Following cond=0001 -> out_valid=0 and annul_count=1.
- Signed compare: flags set to N=1, V=0:
  - cond=1011 (LT) -> cond_pass=1.
  - cond=1010 (GE) -> cond_pass=0.
  - cond=1101 (LE) -> cond_pass=1.
  - cond=1111 -> cond_pass=0.
- Stall: capture result 32'h0000_00AA, then stall=1 for 3 cycles with new inputs 32'h55 -> out_result stays 32'hAA and flags unchanged. After release, out_result=32'h55.
- Flush over stall: flush=1, stall=1, in_valid=1, set_flags=1 -> out_valid=0, out_reg_we=0, out_mem_we=0, flags unchanged, annul_count unchanged.
- Counter wrap: preload annul_count via 65535 annulled instructions (cond=0010) -> reads 16'hFFFF. One more annulled instruction -> 16'h0000.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with ARM condition evaluation, NZV flag
// register, stall/flush handling and a wrapping annulled-instruction counter.
module ex_mem_stage #(
  parameter int unsigned N  = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_v,
  input  logic          set_flags,
  input  logic [3:0]    cond,
  input  logic          reg_we_in,
  input  logic          mem_we_in,
  input  logic [RW-1:0] rd_in,
  input  logic [N-1:0]  store_data_in,
  output logic          cond_pass,
  output logic          out_valid,
  output logic          out_reg_we,
  output logic          out_mem_we,
  output logic [N-1:0]  out_result,
  output logic [N-1:0]  out_store_data,
  output logic [RW-1:0] out_rd,
  output logic [2:0]    flags_nzv,
  output logic [15:0]   annul_count
);

  localparam int unsigned CntW = 16;

  logic          valid_q,  valid_d;
  logic          reg_we_q, reg_we_d;
  logic          mem_we_q, mem_we_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  sdata_q,  sdata_d;
  logic [RW-1:0] rd_q,     rd_d;
  logic [2:0]    nzv_q,    nzv_d;
  logic [CntW-1:0] cnt_q,  cnt_d;

  logic flag_n, flag_z, flag_v;
  logic capture, exec;

  assign flag_n = nzv_q[2];
  assign flag_z = nzv_q[1];
  assign flag_v = nzv_q[0];

  // Condition decode uses only the registered flags; carry-based codes never pass.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign capture = in_valid & ~stall & ~flush;
  assign exec    = capture & cond_pass;

  // Next-state: flush bubbles the control bits only, stall holds everything.
  always_comb begin
    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    mem_we_d = mem_we_q;
    result_d = result_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    nzv_d    = nzv_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
      mem_we_d = 1'b0;
    end else if (!stall) begin
      valid_d  = exec;
      reg_we_d = exec & reg_we_in;
      mem_we_d = exec & mem_we_in;
      result_d = alu_result;
      sdata_d  = store_data_in;
      rd_d     = rd_in;
    end
    if (exec && set_flags) begin
      nzv_d = {alu_n, alu_z, alu_v};
    end
    if (capture && !cond_pass) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      result_q <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      nzv_q    <= 3'b000;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      nzv_q    <= nzv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_reg_we     = reg_we_q;
  assign out_mem_we     = mem_we_q;
  assign out_result     = result_q;
  assign out_store_data = sdata_q;
  assign out_rd         = rd_q;
  assign flags_nzv      = nzv_q;
  assign annul_count    = cnt_q;

endmodule
